// File: rtl/blink_scheduler.sv
// Multi-channel blink timebase: 1 ms prescaler, per-channel period/on-time phase
// counters, and blink outputs that only update on vsync so they never tear mid-frame.
module blink_scheduler #(
  parameter int CLK_KHZ  = 25000,
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2,
  parameter int PERIOD_W = 12
) (
  input  logic                vgaclk_i,
  input  logic                vgarstn_i,
  input  logic                vsync_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [CH_W-1:0]     cfg_ch_i,
  input  logic                cfg_en_i,
  input  logic [PERIOD_W-1:0] cfg_period_i,
  input  logic [PERIOD_W-1:0] cfg_on_i,
  output logic                ms_tick_o,
  output logic [NUM_CH-1:0]   blink_o
);

  localparam int PRE_W = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_KHZ - 1);

  typedef enum logic {IDLE, UPDATE} state_t;

  logic [PRE_W-1:0]    pre_cnt_reg;
  state_t              state_reg;
  logic [CH_W-1:0]     lat_ch_reg;
  logic                lat_en_reg;
  logic [PERIOD_W-1:0] lat_period_reg;
  logic [PERIOD_W-1:0] lat_on_reg;
  logic [NUM_CH-1:0]   raw;

  always_ff @(posedge vgaclk_i or negedge vgarstn_i) begin
    if (!vgarstn_i) begin
      pre_cnt_reg <= '0;
      ms_tick_o   <= 1'b0;
    end else begin
      ms_tick_o   <= (pre_cnt_reg == PRE_MAX);
      pre_cnt_reg <= (pre_cnt_reg == PRE_MAX) ? '0 : pre_cnt_reg + PRE_W'(1);
    end
  end

  // Two-state config handshake: accept in IDLE, commit to the channel in UPDATE.
  always_ff @(posedge vgaclk_i or negedge vgarstn_i) begin
    if (!vgarstn_i) begin
      state_reg      <= IDLE;
      cfg_ready_o    <= 1'b1;
      lat_ch_reg     <= '0;
      lat_en_reg     <= 1'b0;
      lat_period_reg <= '0;
      lat_on_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cfg_valid_i) begin
            lat_ch_reg     <= cfg_ch_i;
            lat_en_reg     <= cfg_en_i;
            lat_period_reg <= cfg_period_i;
            lat_on_reg     <= cfg_on_i;
            state_reg      <= UPDATE;
            cfg_ready_o    <= 1'b0;
          end
        end
        UPDATE: begin
          state_reg   <= IDLE;
          cfg_ready_o <= 1'b1;
        end
        default: begin
          state_reg   <= IDLE;
          cfg_ready_o <= 1'b1;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
    logic                en_reg;
    logic [PERIOD_W-1:0] period_reg;
    logic [PERIOD_W-1:0] on_reg;
    logic [PERIOD_W-1:0] phase_reg;
    logic                wr;

    // Channel selects >= NUM_CH match no channel, so such writes are dropped.
    assign wr = (state_reg == UPDATE) && (lat_ch_reg == CH_W'(gi));

    always_ff @(posedge vgaclk_i or negedge vgarstn_i) begin
      if (!vgarstn_i) begin
        en_reg     <= 1'b0;
        period_reg <= '0;
        on_reg     <= '0;
        phase_reg  <= '0;
      end else if (wr) begin
        en_reg     <= lat_en_reg;
        period_reg <= lat_period_reg;
        on_reg     <= lat_on_reg;
        phase_reg  <= '0;
      end else if (ms_tick_o) begin
        if (en_reg && (period_reg != '0))
          phase_reg <= (phase_reg == period_reg - PERIOD_W'(1)) ? '0 : phase_reg + PERIOD_W'(1);
        else
          phase_reg <= '0;
      end
    end

    assign raw[gi] = en_reg && (period_reg != '0) && (phase_reg < on_reg);
  end

  // Sampling raw here (before any same-edge phase step) gives the pre-increment level.
  always_ff @(posedge vgaclk_i or negedge vgarstn_i) begin
    if (!vgarstn_i)
      blink_o <= '0;
    else if (vsync_i)
      blink_o <= raw;
  end

endmodule

// File: tb/tb_blink_scheduler.sv
// Randomized + directed bench for blink_scheduler: a stimulus process pushes per-cycle
// expectations from an arithmetic model; a monitor pops and compares DUT outputs.
module tb_blink_scheduler;
  localparam int K   = 4;
  localparam int NCH = 3;
  localparam int CW  = 2;
  localparam int PW  = 12;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           vsync = 1'b0;
  logic           valid = 1'b0;
  logic [CW-1:0]  ch = '0;
  logic           en = 1'b0;
  logic [PW-1:0]  per = '0;
  logic [PW-1:0]  on_t = '0;
  logic           ready;
  logic           tick;
  logic [NCH-1:0] blink;

  always #5 clk = ~clk;

  blink_scheduler #(.CLK_KHZ(K), .NUM_CH(NCH), .CH_W(CW), .PERIOD_W(PW)) dut (
    .vgaclk_i(clk), .vgarstn_i(rst_n), .vsync_i(vsync),
    .cfg_valid_i(valid), .cfg_ready_o(ready), .cfg_ch_i(ch), .cfg_en_i(en),
    .cfg_period_i(per), .cfg_on_i(on_t), .ms_tick_o(tick), .blink_o(blink)
  );

  typedef struct {
    int             cyc;
    bit             tick;
    bit             ready;
    logic [NCH-1:0] blink;
  } exp_t;

  exp_t exp_q[$];
  exp_t mx;
  int checks = 0;
  int failures = 0;
  int model_acc = 0;
  int dut_acc = 0;

  // Model: cycle index since reset release, per-channel config and the edge it was written.
  int cyc;
  bit m_ready;
  logic [NCH-1:0] m_blink;
  int m_en[NCH], m_per[NCH], m_on[NCH], m_w[NCH];
  bit pend;
  int p_ch, p_en, p_per, p_on;

  task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, got, expv);
    end
  endtask

  // Phase updates land on edges K+1, 2K+1, ...; count those in (0, x].
  function automatic int ticks_upto(input int x);
    return (x >= 1) ? (x - 1) / K : 0;
  endfunction

  function automatic bit raw_of(input int i, input int e);
    int ph;
    if (m_en[i] == 0 || m_per[i] == 0) return 1'b0;
    ph = (ticks_upto(e - 1) - ticks_upto(m_w[i])) % m_per[i];
    return ph < m_on[i];
  endfunction

  task automatic model_reset();
    cyc = 1;
    m_ready = 1'b1;
    m_blink = '0;
    pend = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = 0; m_per[i] = 0; m_on[i] = 0; m_w[i] = 0;
    end
  endtask

  task automatic step(input bit vs, input bit v, input int c, input int e_, input int p, input int o);
    exp_t x;
    @(negedge clk);
    x.cyc = cyc;
    x.tick = (cyc > 0) && (cyc % K == 0);
    x.ready = m_ready;
    x.blink = m_blink;
    exp_q.push_back(x);
    vsync = vs; valid = v; ch = c[CW-1:0]; en = e_[0]; per = p[PW-1:0]; on_t = o[PW-1:0];
    if (vs)
      for (int i = 0; i < NCH; i++) m_blink[i] = raw_of(i, cyc + 1);
    if (pend) begin
      if (p_ch < NCH) begin
        m_en[p_ch] = p_en; m_per[p_ch] = p_per; m_on[p_ch] = p_on; m_w[p_ch] = cyc + 1;
      end
      pend = 1'b0;
    end
    if (v && m_ready) begin
      pend = 1'b1; p_ch = c % 4; p_en = e_ & 1; p_per = p & 'hFFF; p_on = o & 'hFFF;
      m_ready = 1'b0;
      model_acc++;
      $display("cfg write cyc=%0d ch=%0d en=%0d period=%0d on=%0d", cyc, p_ch, p_en, p_per, p_on);
    end else begin
      m_ready = 1'b1;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input int vs_mod);
    for (int i = 0; i < n; i++) step((vs_mod > 0) && (cyc % vs_mod == 0), 0, 0, 0, 0, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    vsync = 0; valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  always @(posedge clk)
    if (rst_n && valid && ready) dut_acc <= dut_acc + 1;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        mx = exp_q.pop_front();
        chk("ms_tick", mx.cyc, 32'(tick), 32'(mx.tick));
        chk("cfg_ready", mx.cyc, 32'(ready), 32'(mx.ready));
        chk("blink", mx.cyc, 32'(blink), 32'(mx.blink));
      end
    end
  end

  initial begin
    release_reset();
    idle(14, 0);
    // Basic blink with vsync on every tick cycle.
    step(0, 1, 0, 1, 4, 2);
    idle(40, K);
    // Frame alignment: vsync every third tick.
    step(0, 1, 1, 1, 2, 1);
    idle(60, 3 * K);
    // Held valid for 6 cycles, then a write to a nonexistent channel.
    for (int i = 0; i < 6; i++) step(0, 1, 2, 1, 3, 1);
    step(0, 1, 3, 1, 2, 1);
    idle(20, K);
    // Corner configurations.
    step(0, 1, 0, 1, 4, 0); step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 4, 5); step(0, 0, 0, 0, 0, 0);
    step(0, 1, 2, 1, 0, 3);
    idle(30, K);
    step(0, 1, 1, 0, 4, 5);
    idle(12, K);
    // Config commit coincident with a phase-update edge.
    while (cyc % K != K - 1) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 3, 1);
    idle(20, 1);
    // Random traffic.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3),
           ($urandom_range(0, 4) != 0), $urandom_range(0, 7), $urandom_range(0, 8));
    // Reset asserted during UPDATE with a lit channel.
    idle(2, 0);
    step(0, 1, 0, 1, 4, 2); step(0, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 4, 2); step(0, 0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_tick", -1, 32'(tick), 32'd0);
    chk("rst_ready", -1, 32'(ready), 32'd1);
    chk("rst_blink", -1, 32'(blink), 32'd0);
    release_reset();
    idle(20, 2);
    step(0, 1, 1, 1, 3, 2);
    idle(30, K);
    @(negedge clk);
    #3;
    chk("queue_drained", -1, 32'(exp_q.size()), 32'd0);
    chk("accept_count", -1, 32'(dut_acc), 32'(model_acc));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
